// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
// Iterative RV32M multiply/divide unit fed by the register file read ports.
// One operation in flight: 32 shift-add (multiply) or restoring
// shift-subtract (divide) iterations, then a sign-fix cycle and a one-cycle
// completion pulse that drives the register file write port.
//
// Handshake: i_start is accepted only when o_busy=0 (state IDLE); a start
// at any other time, including the DONE cycle, is dropped. o_done is a
// single-cycle pulse; o_result/o_rd_out are valid while o_done=1 and hold
// until the next completion or reset. i_kill aborts an operation in CALC or
// FIX with no completion pulse.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            request (sampled in IDLE only)
//   i_funct3           M-extension operation select
//   i_op_a, i_op_b     rs1 / rs2 data
//   i_rd_in            destination register index
//   i_kill             abort of the in-flight operation
//   o_busy             high in every state except IDLE
//   o_done             one-cycle completion pulse
//   o_result           operation result
//   o_rd_out           destination index of the completed operation
//   o_reg_write        o_done AND (o_rd_out != 0)
//   o_dbg_state        current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
module riscv_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [4:0]      i_rd_in,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_out,
  output logic            o_reg_write,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_neg;      // sign of the selected result
  logic            r_special;  // result preset in r_acc[31:0], no fix-up
  logic [5:0]      r_cnt;
  logic [63:0]     r_acc;      // multiply: {hi, multiplier/lo}; divide: quotient in [31:0]
  logic [31:0]     r_b;        // multiplicand or divisor magnitude
  logic [31:0]     r_rem;      // divide partial remainder (always < divisor)

  // ---------------- start-time operand decode ----------------
  logic        w_a_signed, w_b_signed, w_div_zero, w_ovf, w_special, w_neg;
  logic [31:0] w_a_mag, w_b_mag, w_preset;

  always_comb begin
    w_a_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                 (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    w_b_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    w_a_mag    = (w_a_signed && i_op_a[31]) ? (~i_op_a + 32'd1) : i_op_a;
    w_b_mag    = (w_b_signed && i_op_b[31]) ? (~i_op_b + 32'd1) : i_op_b;
    w_div_zero = i_funct3[2] && (i_op_b == 32'd0);
    w_ovf      = i_funct3[2] && !i_funct3[0] &&
                 (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
    w_special  = w_div_zero || w_ovf;
    // funct3[1] separates remainder from quotient among the divides
    if (w_div_zero) w_preset = i_funct3[1] ? i_op_a : 32'hFFFF_FFFF;
    else            w_preset = i_funct3[1] ? 32'd0  : 32'h8000_0000;
    case (i_funct3)
      3'b001, 3'b100: w_neg = i_op_a[31] ^ i_op_b[31];
      3'b010, 3'b110: w_neg = i_op_a[31];
      default:        w_neg = 1'b0;
    endcase
  end

  // ---------------- iteration datapath ----------------
  logic [32:0] w_mul_add, w_mul_sum, w_shift, w_trial;

  always_comb begin
    w_mul_add = r_acc[0] ? {1'b0, r_b} : 33'd0;
    w_mul_sum = {1'b0, r_acc[63:32]} + w_mul_add;
    // 33-bit partial remainder: previous remainder shifted in with the next dividend bit
    w_shift   = {r_rem, r_acc[31]};
    w_trial   = w_shift - {1'b0, r_b};
  end

  // ---------------- sign fix and output select ----------------
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_remv, w_fix_val;

  always_comb begin
    w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
    w_quo  = r_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_remv = r_neg ? (~r_rem + 32'd1) : r_rem;
    case (r_funct3)
      3'b000:                 w_fix_val = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_fix_val = w_prod[63:32];
      3'b100, 3'b101:         w_fix_val = w_quo;
      default:                w_fix_val = w_remv;
    endcase
    if (r_special) w_fix_val = r_acc[31:0];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = w_special ? S_FIX : S_CALC;
      S_CALC: begin
        if (i_kill)                        w_next = S_IDLE;
        else if (r_cnt == 6'(ITER - 1))    w_next = S_FIX;
      end
      S_FIX:  w_next = i_kill ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_funct3  <= 3'd0;
      r_rd      <= 5'd0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_cnt     <= 6'd0;
      r_acc     <= 64'd0;
      r_b       <= 32'd0;
      r_rem     <= 32'd0;
      o_result  <= 32'd0;
      o_rd_out  <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_funct3  <= i_funct3;
          r_rd      <= i_rd_in;
          r_neg     <= w_special ? 1'b0 : w_neg;
          r_special <= w_special;
          r_cnt     <= 6'd0;
          r_rem     <= 32'd0;
          r_b       <= w_b_mag;
          r_acc     <= {32'd0, (w_special ? w_preset : w_a_mag)};
        end
        S_CALC: if (!i_kill) begin
          r_cnt <= r_cnt + 6'd1;
          if (r_funct3[2]) begin
            if (w_trial[32]) begin
              r_rem        <= w_shift[31:0];
              r_acc[31:0]  <= {r_acc[30:0], 1'b0};
            end else begin
              r_rem        <= w_trial[31:0];
              r_acc[31:0]  <= {r_acc[30:0], 1'b1};
            end
          end else begin
            r_acc <= {w_mul_sum, r_acc[31:1]};
          end
        end
        S_FIX: if (!i_kill) begin
          o_result <= w_fix_val;
          o_rd_out <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_reg_write = o_done && (o_rd_out != 5'd0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit: directed vectors, special
// cases, randomized operations against an arithmetic reference model,
// handshake/kill behaviour and asynchronous reset.
module tb_riscv_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  riscv_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_funct3(funct3),
    .i_op_a(op_a), .i_op_b(op_b), .i_rd_in(rd_in), .i_kill(kill),
    .o_busy(busy), .o_done(done), .o_result(result), .o_rd_out(rd_out),
    .o_reg_write(reg_write), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counts completion pulses (sampled at the edge that ends each cycle)
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      la, lb, lp;
    logic [63:0] up;
    ia = a; ib = b;
    la = ia; lb = ib;
    case (f)
      3'd0: return a * b;
      3'd1: begin lp = la * lb; up = lp; return up[63:32]; end
      3'd2: begin lb = {32'd0, b}; lp = la * lb; up = lp; return up[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // ---------------- driver ----------------
  // Issues one request and waits (bounded) for the completion pulse.
  // lat counts clock edges after the accepting edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output logic rw, output int lat, output bit seen);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    seen = (done === 1'b1);
    res = result; rdo = rd_out; rw = reg_write;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'd0;
    op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0)    begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (rd_out !== 5'd0)     begin errors++; $display("FAIL reset_rd_out got=%0d exp=0", rd_out); end
    checks++; if (reg_write !== 1'b0)  begin errors++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  task automatic test_directed;
    vec_t v[12];
    logic [31:0] res; logic [4:0] rdo; logic rw; int lat; bit seen;
    v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    v[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    v[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    v[8]  = '{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, 1};
    v[9]  = '{3'd7, 32'h1234,       32'd0,         32'h1234,      1};
    v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    for (int i = 0; i < 12; i++) begin
      do_op(v[i].f, v[i].a, v[i].b, 5'd5, res, rdo, rw, lat, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL dir%0d_timeout no done within budget", i);
      end else begin
        if (res !== v[i].exp) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, v[i].exp); end
        checks++; if (lat != v[i].lat) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
        checks++; if (rdo !== 5'd5)    begin errors++; $display("FAIL dir%0d_rd_out got=%0d exp=5", i, rdo); end
        checks++; if (rw !== 1'b1)     begin errors++; $display("FAIL dir%0d_reg_write got=%b exp=1", i, rw); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || reg_write !== 1'b0)
          begin errors++; $display("FAIL dir%0d_pulse_width done=%b reg_write=%b exp=0", i, done, reg_write); end
        checks++; if (result !== v[i].exp) begin errors++; $display("FAIL dir%0d_hold got=%h exp=%h", i, result, v[i].exp); end
      end
    end
  endtask

  function automatic logic [31:0] pick_operand;
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [31:0] a, b, res, exp; logic [2:0] f; logic [4:0] rd, rdo; logic rw; int lat; bit seen;
    for (int i = 0; i < 60; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      rd = 5'($urandom_range(0, 31));
      exp = ref_result(f, a, b);
      do_op(f, a, b, rd, res, rdo, rw, lat, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rnd%0d_timeout f=%0d a=%h b=%h", i, f, a, b);
      end else begin
        if (res !== exp) begin errors++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, res, exp); end
        checks++; if (lat != ref_latency(f, a, b))
          begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, ref_latency(f, a, b)); end
        checks++; if (rdo !== rd) begin errors++; $display("FAIL rnd%0d_rd_out got=%0d exp=%0d", i, rdo, rd); end
        checks++; if (rw !== (rd != 0)) begin errors++; $display("FAIL rnd%0d_reg_write got=%b exp=%b", i, rw, rd != 0); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] exp;
    exp = ref_result(3'd5, 32'd1000, 32'd3);
    @(negedge clk);
    done_cnt = 0;
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    // second request while busy must be dropped
    start = 1'b1; funct3 = 3'd0; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd10;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_timeout no done within budget");
    end else begin
      if (result !== exp) begin errors++; $display("FAIL b2b_result got=%h exp=%h", result, exp); end
      checks++; if (rd_out !== 5'd9) begin errors++; $display("FAIL b2b_rd_out got=%0d exp=9", rd_out); end
      // start during the DONE cycle is also dropped
      start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done busy=%b exp=0", busy); end
    end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_rd_zero;
    logic [31:0] res; logic [4:0] rdo; logic rw; int lat; bit seen;
    do_op(3'd0, 32'd6, 32'd9, 5'd0, res, rdo, rw, lat, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rd0_timeout no done within budget");
    end else begin
      if (rw !== 1'b0) begin errors++; $display("FAIL rd0_reg_write got=%b exp=0", rw); end
      checks++; if (res !== 32'd54) begin errors++; $display("FAIL rd0_result got=%h exp=%h", res, 32'd54); end
    end
  endtask

  task automatic test_kill;
    logic [31:0] prior;
    prior = result;
    @(negedge clk);
    done_cnt = 0;
    start = 1'b1; funct3 = 3'd0; op_a = 32'h1111; op_b = 32'h2222; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got=%b exp=0", busy); end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL kill_done_count got=%0d exp=0", done_cnt); end
    checks++; if (result !== prior) begin errors++; $display("FAIL kill_result got=%h exp=%h", result, prior); end
    // start and kill together in IDLE: the request is accepted
    start = 1'b1; kill = 1'b1; funct3 = 3'd3; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd4;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kill_start_busy got=%b exp=1", busy); end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL kill_start_done_count got=%0d exp=1", done_cnt); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL kill_start_result got=%h exp=0", result); end
  endtask

  task automatic test_async_reset;
    logic [31:0] res; logic [4:0] rdo; logic rw; int lat; bit seen;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd1; op_a = 32'h1234_5678; op_b = 32'h8765_4321; rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL arst_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL arst_result got=%h exp=0", result); end
    checks++; if (rd_out !== 5'd0)  begin errors++; $display("FAIL arst_rd_out got=%0d exp=0", rd_out); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd4, 5'd2, res, rdo, rw, lat, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL arst_mul_timeout no done within budget");
    end else if (res !== 32'd12) begin
      errors++; $display("FAIL arst_mul_result got=%h exp=%h", res, 32'd12);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_rd_zero();
    test_kill();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file. Consumes the two read ports (rs1/rs2 data) plus the destination index. Computes one M-extension operation over multiple cycles. Returns the 32-bit result, destination index and write strobe that feed the register file write port (write_data / rd / reg_Write).

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, iterations per mul/div; must equal XLEN.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  32  rs1 data (rd1)
op_b  input  32  rs2 data (rd2)
rd_in  input  5  destination register index
kill  input  1  synchronous abort of the in-flight operation
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
result  output  32  operation result, valid while done=1
rd_out  output  5  rd_in latched at start
reg_write  output  1  equals done AND (rd_out != 0)

Behaviour:
- Reset: asynchronous and active-low. Asserting rst_n=0 at any time, including mid-operation, forces IDLE.
  - busy=0, done=0, reg_write=0, result=0, rd_out=0.
  - All internal registers are cleared. There is no partial writeback.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, edge E0 with start=1:
  - Latch funct3 and rd_in.
  - Latch operand magnitudes and result sign:
    - signed ops (MULH, DIV, REM): take abs of both operands;
    - MULHSU: take abs of op_a only;
    - MUL, MULHU, DIVU, REMU: use operands as given.
  - Clear the iteration counter and go to CALC.
  - Special cases skip CALC and go straight to FIX with the result preset:
    - divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
    - DIV/REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per edge, 32 edges (E1..E32), 6-bit counter. Then go to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract with a 33-bit partial remainder.
- FIX: one edge.
  - Apply two's-complement negation to the 64-bit product when the result sign is negative.
  - For division, the quotient takes the sign of op_a XOR op_b; the remainder takes the sign of op_a.
  - Select the output: low word for MUL, high word for MULH/MULHSU/MULHU, quotient or remainder for divides.
  - Register the selected value into result, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - normal operation: done is high in the cycle after edge E33 (34 cycles from start);
  - special cases: done is high in the cycle after edge E1.
- start while busy=1 is ignored, with no queueing.
- start in the same cycle as a DONE pulse is ignored, because busy is still 1.
- result holds its value after done until the next completion or reset. rd_out holds likewise.
- kill=1 in CALC or FIX: go to IDLE on the next edge. No done pulse; result is unchanged.
- kill in IDLE or DONE has no effect. The DONE pulse still completes.
- kill and start together in IDLE: start wins.
- reg_write is suppressed when rd_out = 0. done still pulses.
- All arithmetic is modulo 2^32 on the output. The internal product is the full 64 bits with no truncation before FIX.

Test Plan:
1. MUL, op_a=7, op_b=0xFFFFFFFD, rd_in=5 -> done in cycle 34; result=0xFFFFFFEB; rd_out=5; reg_write=1 for one cycle.
2. Multiply high results:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed divide, op_a=0xFFFFFFF9 (-7), op_b=2:
   - DIV -> 0xFFFFFFFD.
   - REM -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Special cases:
   - DIVU 0x1234 / 0 -> 0xFFFFFFFF, done in the cycle after E1.
   - REMU 0x1234 / 0 -> 0x1234.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
5. Control and handshake:
   - Second start while busy is ignored; only one done pulse occurs.
   - rd_in=0 -> done=1 with reg_write=0.
   - kill at iteration 10 -> IDLE next edge, no done, result keeps its prior value.
6. rst_n driven low asynchronously at iteration 20 (mid-cycle) -> busy/done/result/rd_out go to 0 immediately. After release, a fresh MUL 3x4 returns 12.
